// File: rtl/lw_hmac_seq.sv
// HMAC sequencer in front of an external streaming SHA core: ipad key block, message, outer pass.
// Compile-time option HMAC_KEY_RETAIN_EN keeps the key between operations for reuse_key_i.
module lw_hmac_seq #(
    parameter int unsigned WORD_W       = 32,
    parameter int unsigned DIGEST_WORDS = 8
) (
    input  logic                           clk_i,
    input  logic                           aresetn_i,
    input  logic                           start_i,
    input  logic                           abort_i,
    input  logic                           reuse_key_i,
    input  logic [WORD_W-1:0]              key_i,
    input  logic                           key_valid_i,
    input  logic                           key_last_i,
    output logic                           key_ready_o,
    input  logic [WORD_W-1:0]              msg_i,
    input  logic                           msg_valid_i,
    input  logic                           msg_last_i,
    output logic                           msg_ready_o,
    output logic                           core_start_o,
    output logic [WORD_W-1:0]              core_data_o,
    output logic                           core_valid_o,
    output logic                           core_last_o,
    input  logic                           core_ready_i,
    input  logic                           core_done_i,
    input  logic [DIGEST_WORDS*WORD_W-1:0] core_hash_i,
    output logic [DIGEST_WORDS*WORD_W-1:0] hash_o,
    output logic                           done_o,
    output logic                           busy_o
);
    localparam logic [WORD_W-1:0] Ipad     = {(WORD_W/8){8'h36}};
    localparam logic [WORD_W-1:0] Opad     = {(WORD_W/8){8'h5c}};
    localparam logic [WORD_W-1:0] PadOne   = {1'b1, {(WORD_W-1){1'b0}}};
    localparam logic [WORD_W-1:0] OuterLen = WORD_W'((16 + DIGEST_WORDS) * WORD_W);
    localparam logic [3:0]        DwIdx    = 4'(DIGEST_WORDS);

    typedef enum logic [2:0] {
        StIdle, StKey, StMsg, StIwait, StOkey, StOdata, StOwait
    } state_e;

    state_e                         state_q, state_d;
    logic [3:0]                     cnt_q;
    logic                           key_done_q, reuse_q, core_start_q, done_q;
    logic [WORD_W-1:0]              key_q   [16];
    logic [WORD_W-1:0]              inner_q [16];
    logic [DIGEST_WORDS*WORD_W-1:0] hash_q;
    logic                           reuse_req, loading, xfer, abort_act;
    logic [WORD_W-1:0]              odata_word;

`ifdef HMAC_KEY_RETAIN_EN
    assign reuse_req = reuse_key_i;
`else
    logic unused_reuse_key;
    assign unused_reuse_key = reuse_key_i;
    assign reuse_req        = 1'b0;
`endif

    assign abort_act = abort_i && (state_q != StIdle);
    // Key words come from the input stream until key_last or reuse; after that from key_q.
    assign loading   = (state_q == StKey) && !key_done_q && !reuse_q;
    assign xfer      = core_valid_o && core_ready_i;

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_act) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (start_i) state_d = StKey;
                StKey:   if (xfer && cnt_q == 4'd15) state_d = StMsg;
                StMsg:   if (xfer && msg_last_i) state_d = StIwait;
                StIwait: if (core_done_i) state_d = StOkey;
                StOkey:  if (xfer && cnt_q == 4'd15) state_d = StOdata;
                StOdata: if (xfer && cnt_q == 4'd15) state_d = StOwait;
                StOwait: if (core_done_i) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Outer-hash block: inner digest, padding bit, zeros, then total bit length.
    always_comb begin
        odata_word = '0;
        if (cnt_q < DwIdx) begin
            odata_word = inner_q[cnt_q];
        end else if (cnt_q == DwIdx) begin
            odata_word = PadOne;
        end else if (cnt_q == 4'd15) begin
            odata_word = OuterLen;
        end
    end

    always_comb begin
        key_ready_o  = 1'b0;
        msg_ready_o  = 1'b0;
        core_valid_o = 1'b0;
        core_last_o  = 1'b0;
        core_data_o  = '0;
        case (state_q)
            StKey: begin
                key_ready_o  = loading && core_ready_i;
                core_valid_o = loading ? key_valid_i : 1'b1;
                core_data_o  = (loading ? key_i : key_q[cnt_q]) ^ Ipad;
            end
            StMsg: begin
                msg_ready_o  = core_ready_i;
                core_valid_o = msg_valid_i;
                core_last_o  = msg_last_i;
                core_data_o  = msg_i;
            end
            StOkey: begin
                core_valid_o = 1'b1;
                core_data_o  = key_q[cnt_q] ^ Opad;
            end
            StOdata: begin
                core_valid_o = 1'b1;
                core_last_o  = (cnt_q == 4'd15);
                core_data_o  = odata_word;
            end
            default: ;
        endcase
    end

    assign busy_o       = (state_q != StIdle);
    assign core_start_o = core_start_q;
    assign done_o       = done_q;
    assign hash_o       = hash_q;

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            cnt_q        <= '0;
            key_done_q   <= 1'b0;
            reuse_q      <= 1'b0;
            core_start_q <= 1'b0;
            done_q       <= 1'b0;
            hash_q       <= '0;
            for (int i = 0; i < 16; i++) begin
                key_q[i]   <= '0;
                inner_q[i] <= '0;
            end
        end else begin
            core_start_q <= 1'b0;
            done_q       <= 1'b0;
            if (abort_act) begin
                cnt_q      <= '0;
                key_done_q <= 1'b0;
                reuse_q    <= 1'b0;
                for (int i = 0; i < 16; i++) begin
                    key_q[i]   <= '0;
                    inner_q[i] <= '0;
                end
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start_i) begin
                            core_start_q <= 1'b1;
                            cnt_q        <= '0;
                            key_done_q   <= 1'b0;
                            reuse_q      <= reuse_req;
                            // Fresh key: clear so short keys read back as zero words.
                            if (!reuse_req) begin
                                for (int i = 0; i < 16; i++) key_q[i] <= '0;
                            end
                        end
                    end
                    StKey: begin
                        if (xfer) begin
                            cnt_q <= cnt_q + 4'd1;
                            if (loading) begin
                                key_q[cnt_q] <= key_i;
                                if (key_last_i) key_done_q <= 1'b1;
                            end
                        end
                    end
                    StIwait: begin
                        if (core_done_i) begin
                            for (int i = 0; i < int'(DIGEST_WORDS); i++) begin
                                inner_q[i] <= core_hash_i[(DIGEST_WORDS-1-i)*WORD_W +: WORD_W];
                            end
                            core_start_q <= 1'b1;
                            cnt_q        <= '0;
                        end
                    end
                    StOkey, StOdata: begin
                        if (xfer) cnt_q <= cnt_q + 4'd1;
                    end
                    StOwait: begin
                        if (core_done_i) begin
                            hash_q <= core_hash_i;
                            done_q <= 1'b1;
`ifndef HMAC_KEY_RETAIN_EN
                            for (int i = 0; i < 16; i++) key_q[i] <= '0;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/lw_hmac_seq.md
LW_HMAC_SEQ -- requirements
Module: lw_hmac_seq

Interface
REQ-001 Parameter WORD_W, default 32, SHALL set the data, key and core word width; only 32 or 64 are legal.
REQ-002 Parameter DIGEST_WORDS, default 8, SHALL set the digest length in words; legal range is 1..14.
REQ-003 clk_i  in  1  clock; all logic SHALL be on the rising edge.
REQ-004 aresetn_i  in  1  reset, asynchronous, active-low.
REQ-005 start_i  in  1  starts one HMAC operation; sampled only in IDLE.
REQ-006 abort_i  in  1  cancels the current operation.
REQ-007 reuse_key_i  in  1  sampled with start_i; reuses the stored key.
REQ-008 key_i / key_valid_i / key_last_i / key_ready_o  in/in/in/out  WORD_W/1/1/1  key stream, MSW first.
REQ-009 msg_i / msg_valid_i / msg_last_i / msg_ready_o  in/in/in/out  WORD_W/1/1/1  message stream.
REQ-010 core_start_o / core_data_o / core_valid_o / core_last_o  out  1/WORD_W/1/1  drive the SHA core.
REQ-011 core_ready_i / core_done_i / core_hash_i  in  1/1/DIGEST_WORDS*WORD_W  responses from the SHA core.
REQ-012 hash_o / done_o / busy_o  out  DIGEST_WORDS*WORD_W/1/1  result, completion pulse, and not-IDLE flag.

Function
REQ-013 A transfer SHALL occur only on a cycle where valid and ready are both high; this applies to every stream.
REQ-014 The FSM SHALL have the states IDLE, KEY, MSG, IWAIT, OKEY, ODATA, OWAIT.
  - Transitions: IDLE->KEY on start_i; KEY->MSG after 16 core words; MSG->IWAIT on the msg_last_i transfer; IWAIT->OKEY on core_done_i; OKEY->ODATA after 16 words; ODATA->OWAIT after 16 words; OWAIT->IDLE on core_done_i.
REQ-015 core_start_o SHALL pulse for one cycle on entry to KEY and on entry to OKEY.
REQ-016 KEY state behaviour:
  - key_ready_o = core_ready_i until key_last_i is transferred or 16 words have been taken.
  - Each core word = key word XOR the ipad pattern (bytes 0x36).
  - Key words are stored in a 16-entry key register.
  - After key_last_i, the remaining words up to 16 SHALL be zero key words (core_data_o = ipad pattern), with key_ready_o low.
REQ-017 A key longer than 16 words SHALL NOT be accepted: key_ready_o is low after the 16th word and the extra words are ignored.
REQ-018 MSG state SHALL pass the message through combinationally:
  - core_data_o = msg_i; core_valid_o = msg_valid_i; msg_ready_o = core_ready_i; core_last_o = msg_last_i.
  - At least one message word is required.
REQ-019 On core_done_i in IWAIT, core_hash_i SHALL be captured into the inner-digest register.
REQ-020 OKEY state SHALL stream the stored key words XOR the opad pattern (bytes 0x5c), 16 words, with core_valid_o high.
REQ-021 ODATA state SHALL stream 16 words with core_valid_o high, indexed by word i:
  - i < DIGEST_WORDS: inner digest word i, MSW first.
  - i = DIGEST_WORDS: only bit WORD_W-1 set.
  - DIGEST_WORDS < i < 15: zero.
  - i = 15: (16+DIGEST_WORDS)*WORD_W.
  - core_last_o is high on word 15.
REQ-022 On core_done_i in OWAIT, the FSM SHALL register hash_o <= core_hash_i and pulse done_o for exactly one cycle, one cycle after core_done_i.
REQ-023 abort_i in any non-IDLE state SHALL:
  - return the FSM to IDLE on the next cycle;
  - produce no done_o;
  - clear the key register and inner-digest register;
  - leave hash_o at its previous value.
REQ-024 abort_i takes priority over a simultaneous core_done_i.
REQ-025 start_i outside IDLE SHALL be ignored.
REQ-026 busy_o SHALL be high in every state except IDLE.
REQ-027 key_ready_o and msg_ready_o SHALL be low outside KEY and MSG respectively.
REQ-028 At normal completion, the key register SHALL be cleared unless retention applies (REQ-032).

Reset
REQ-029 On aresetn_i low, the block SHALL asynchronously force:
  - FSM = IDLE;
  - the key register, inner-digest register and hash_o to zero;
  - done_o, busy_o, core_start_o, core_valid_o, core_last_o, key_ready_o, msg_ready_o to 0.
REQ-030 A reset asserted mid-operation SHALL discard the operation; the first legal start_i is on the first clock edge after deassertion.

Configuration
REQ-031 The macro HMAC_KEY_RETAIN_EN SHALL select key-retention support at compile time.
REQ-032 With HMAC_KEY_RETAIN_EN defined:
  - start_i with reuse_key_i=1 SHALL skip key input: KEY streams the stored key XOR ipad with key_ready_o low.
  - The key register SHALL be kept at normal completion.
  - The key register SHALL be cleared only on abort or reset.
REQ-033 Without HMAC_KEY_RETAIN_EN:
  - reuse_key_i SHALL be ignored.
  - Every operation SHALL load a key.
  - The key register SHALL be cleared at completion per REQ-028.

Verification
REQ-034 WORD_W=32, DIGEST_WORDS=8, with a SHA-256 core; key 0x4a656665 (key_last_i on word 1); message "what do ya want for nothing?" (7 words, msg_last_i on word 7) -> hash_o = 5bdcc146bf60754e6a042426089575c75a003f089d2739839dec58b964ec3843 and a single done_o pulse.
REQ-035 Same setup; check the ODATA stream -> word 8 = 0x80000000, words 9..14 = 0, word 15 = 0x00000300, core_last_o only on word 15.
REQ-036 WORD_W=64, DIGEST_WORDS=8, with a SHA-512 core; RFC 4231 case 2 -> hash_o = 164b7a7bfcf819e2e395fbe73b56e0a387bd64222e831fd610270cd7ea2505549758bf75c05a994a6d034f65f8f0e6fdcaeab1a34d4a6b4b636e070a38bce737; ODATA word 15 = 0x600.
REQ-037 abort_i asserted on the 3rd MSG transfer -> IDLE next cycle, no done_o, hash_o unchanged, key register zero.
REQ-038 HMAC_KEY_RETAIN_EN defined: run REQ-034, then start_i with reuse_key_i=1 and the same message -> zero key transfers, identical hash_o. Without the macro, the same sequence -> key_ready_o asserted and a key required.
REQ-039 Hold core_ready_i low for 5 cycles mid-KEY -> no word lost or duplicated; hash_o matches REQ-034.
